// File: rtl/display_scroll_controller_pkg.sv
// Shared types and defaults for the scrolling display controller.
package display_scroll_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REFRESH = 2'd1,
    WAIT    = 2'd2
  } state_t;

  localparam int MSG_DEPTH_DEFAULT = 16;

  // Four display digits per refresh burst; this is the last digit index.
  localparam logic [1:0] LAST_POS = 2'd3;

endpackage

// File: rtl/scroll_tick.sv
// Dwell counter between scroll steps: counts while enabled and pulses
// 'terminal' combinationally on the last cycle of each MAX_COUNT window.
module scroll_tick #(
  parameter int unsigned MAX_COUNT = 24'd10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic terminal
);

  localparam int CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MAX_COUNT - 1);

  logic [CW-1:0] count;

  assign terminal = enable && (count == LAST);

  // Count from zero on every entry into the enabled window; idle holds at zero.
  always_ff @(posedge clk) begin
    if (reset || !enable) count <= '0;
    else if (terminal)    count <= '0;
    else                  count <= count + CW'(1);
  end

endmodule

// File: rtl/display_scroll_controller.sv
// Scrolls a short 4-bit-character message across a 4-digit display by
// bursting four load strokes per step, then dwelling MAX_COUNT cycles.
module display_scroll_controller
  import display_scroll_controller_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 24'd10_000_000,
  parameter int          MSG_DEPTH = MSG_DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       start,
  input  logic       clear,
  output logic [3:0] data,
  output logic [1:0] char_position,
  output logic       load,
  output logic       busy
);

  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int IW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;

  state_t        state;
  logic [LW-1:0] len;
  logic [IW-1:0] offset;
  // Index of the character to present on the NEXT load stroke; outputs are
  // registered, so the read runs one stroke ahead of what the display sees.
  logic [IW-1:0] rd_idx;
  logic [1:0]    k;
  logic [3:0]    msg [MSG_DEPTH];
  logic          terminal;
  logic          wr_fire;
  logic [IW-1:0] next_off;

  // Advance a message index, wrapping to 0 after the last valid character.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i,
                                             input logic [LW-1:0] n);
    next_idx = ((LW'(i) + LW'(1)) >= n) ? '0 : i + IW'(1);
  endfunction

  assign wr_ready = (state == IDLE) && (len < LW'(MSG_DEPTH));
  assign wr_fire  = wr_valid && wr_ready && !clear && !reset;
  assign busy     = (state != IDLE);
  assign next_off = next_idx(offset, len);

  scroll_tick #(.MAX_COUNT(MAX_COUNT)) u_tick (
    .clk      (clk),
    .reset    (reset || clear),
    .enable   (state == WAIT),
    .terminal (terminal)
  );

  // Message storage; contents are don't-care until len covers them.
  always_ff @(posedge clk) begin
    if (wr_fire) msg[len[IW-1:0]] <= wr_data;
  end

  // Control FSM with registered display outputs; clear behaves like reset.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state         <= IDLE;
      len           <= '0;
      offset        <= '0;
      rd_idx        <= '0;
      k             <= '0;
      load          <= 1'b0;
      data          <= '0;
      char_position <= '0;
    end else begin
      if (wr_fire) len <= len + LW'(1);
      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            state         <= REFRESH;
            offset        <= '0;
            k             <= '0;
            load          <= 1'b1;
            data          <= msg[0];
            char_position <= '0;
            rd_idx        <= next_idx('0, len);
          end
        end
        REFRESH: begin
          if (k == LAST_POS) begin
            state         <= WAIT;
            load          <= 1'b0;
            data          <= '0;
            char_position <= '0;
          end else begin
            k             <= k + 2'd1;
            char_position <= k + 2'd1;
            data          <= msg[rd_idx];
            rd_idx        <= next_idx(rd_idx, len);
          end
        end
        WAIT: begin
          if (terminal) begin
            state         <= REFRESH;
            offset        <= next_off;
            k             <= '0;
            load          <= 1'b1;
            data          <= msg[next_off];
            char_position <= '0;
            rd_idx        <= next_idx(next_off, len);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_scroll_controller.sv
// Bench for display_scroll_controller: phase/offset reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_display_scroll_controller;

  localparam int MC    = 4;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset, wr_valid, start, clear;
  logic [3:0] wr_data;
  logic       wr_ready, load, busy;
  logic [3:0] data;
  logic [1:0] char_position;

  always #5 clk = ~clk;

  display_scroll_controller #(.MAX_COUNT(MC), .MSG_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .start         (start),
    .clear         (clear),
    .data          (data),
    .char_position (char_position),
    .load          (load),
    .busy          (busy)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  // Reference model: message array, scroll active flag, cycle phase within
  // one scroll period (0..4+MC-1) and the current scroll offset.
  logic [3:0] m_msg [DEPTH];
  int m_len = 0, m_off = 0, m_phase = 0;
  bit m_active = 0;

  typedef struct { int pos; int dat; } ld_t;
  ld_t log_q[$];

  always @(posedge clk) begin : model
    if (reset || clear) begin
      m_len = 0; m_off = 0; m_phase = 0; m_active = 0;
    end else begin
      if (!m_active && wr_valid && m_len < DEPTH) begin
        m_msg[m_len] = wr_data;
        m_len++;
      end
      if (m_active) begin
        m_phase++;
        if (m_phase == 4 + MC) begin
          m_phase = 0;
          m_off = (m_off + 1) % m_len;
        end
      end else if (start && m_len >= 1) begin
        m_active = 1; m_phase = 0; m_off = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic       e_load, e_busy, e_rdy;
    logic [1:0] e_pos;
    logic [3:0] e_dat;
    if (chk_en) begin
      e_load = m_active && (m_phase < 4);
      e_pos  = e_load ? 2'(m_phase) : 2'd0;
      e_dat  = e_load ? m_msg[(m_off + m_phase) % m_len] : 4'd0;
      e_busy = m_active;
      e_rdy  = !m_active && (m_len < DEPTH);
      tests++;
      if ({load, char_position, data, busy, wr_ready} !== {e_load, e_pos, e_dat, e_busy, e_rdy}) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t got load=%0b pos=%0d data=%0d busy=%0b rdy=%0b expected load=%0b pos=%0d data=%0d busy=%0b rdy=%0b",
                 $time, load, char_position, data, busy, wr_ready, e_load, e_pos, e_dat, e_busy, e_rdy);
      end
      if (load === 1'b1) log_q.push_back('{int'(char_position), int'(data)});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit wv, input logic [3:0] wd, input bit st, input bit cl, input bit rs);
    wr_valid = wv; wr_data = wd; start = st; clear = cl; reset = rs;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 4'd0, 0, 0, 0);
  endtask

  int exp_d [12] = '{1, 2, 3, 4, 2, 3, 4, 5, 3, 4, 5, 1};
  logic [3:0] w [DEPTH];

  initial begin
    cyc(0, 4'd0, 0, 0, 1);
    chk_en = 1;
    cyc(0, 4'd0, 0, 0, 1);
    @(negedge clk);
    chk("reset_wr_ready", wr_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_load", load, 0);

    // Five-character scroll across three steps.
    for (int v = 1; v <= 5; v++) cyc(1, 4'(v), 0, 0, 0);
    log_q.delete();
    cyc(0, 4'd0, 1, 0, 0);
    idle(2 * (4 + MC) + 4);
    chk("scroll_load_count", log_q.size(), 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("scroll_pos%0d", i), (i < log_q.size()) ? log_q[i].pos : -1, i % 4);
      chk($sformatf("scroll_dat%0d", i), (i < log_q.size()) ? log_q[i].dat : -1, exp_d[i]);
    end

    // Fill to capacity; overflow and busy writes are refused.
    cyc(0, 4'd0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) begin
      w[i] = 4'((i * 7 + 3) % 16);
      cyc(1, w[i], 0, 0, 0);
    end
    @(negedge clk);
    chk("full_wr_ready", wr_ready, 0);
    cyc(1, 4'hF, 0, 0, 0);
    log_q.delete();
    cyc(0, 4'd0, 1, 0, 0);
    idle(2);
    cyc(1, 4'hE, 0, 0, 0);
    idle(2 * (4 + MC));
    chk("full_first_dat", (log_q.size() > 0) ? log_q[0].dat : -1, w[0]);
    chk("full_step_dat", (log_q.size() > 4) ? log_q[4].dat : -1, w[1]);

    // Single character repeats on every digit.
    cyc(0, 4'd0, 0, 1, 0);
    cyc(1, 4'd7, 0, 0, 0);
    log_q.delete();
    cyc(0, 4'd0, 1, 0, 0);
    idle(3 * (4 + MC));
    chk("single_loads", log_q.size() >= 8, 1);
    foreach (log_q[i]) chk($sformatf("single_dat%0d", i), log_q[i].dat, 7);

    // Start with an empty message is ignored.
    cyc(0, 4'd0, 0, 1, 0);
    cyc(0, 4'd0, 1, 0, 0);
    @(negedge clk);
    chk("empty_busy", busy, 0);
    chk("empty_load", load, 0);
    idle(3);

    // Clear on the second refresh stroke.
    cyc(1, 4'd1, 0, 0, 0);
    cyc(1, 4'd2, 0, 0, 0);
    cyc(0, 4'd0, 1, 0, 0);
    idle(1);
    cyc(0, 4'd0, 0, 1, 0);
    @(negedge clk);
    chk("clear_load", load, 0);
    chk("clear_busy", busy, 0);
    chk("clear_wr_ready", wr_ready, 1);

    // Reset in the middle of the dwell, then a fresh one-character scroll.
    cyc(1, 4'd3, 0, 0, 0);
    cyc(1, 4'd4, 0, 0, 0);
    cyc(0, 4'd0, 1, 0, 0);
    idle(5);
    cyc(0, 4'd0, 0, 0, 1);
    cyc(1, 4'd9, 0, 0, 0);
    cyc(0, 4'd0, 1, 0, 0);
    @(negedge clk);
    chk("rst_restart_load", load, 1);
    chk("rst_restart_pos", char_position, 0);
    chk("rst_restart_dat", data, 9);

    // Randomized traffic against the model.
    repeat (1500) begin
      int  r;
      bit  st, cl, rs, wv;
      r  = $urandom_range(0, 99);
      rs = (r < 1);
      cl = (r >= 1) && (r < 3);
      st = (r >= 3) && (r < 8);
      wv = !st && ($urandom_range(0, 2) == 0);
      cyc(wv, 4'($urandom), st, cl, rs);
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_scroll_controller.md
DISPLAY_SCROLL_CONTROLLER -- requirements
Module: display_scroll_controller

Interface
REQ-001 Parameter MAX_COUNT, default 24'd10_000_000, gives the number of clk cycles between scroll steps.
REQ-002 Parameter MSG_DEPTH, default 16, gives the message buffer capacity in 4-bit characters.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_data  input  4  character code to append to the message.
REQ-006 wr_valid  input  1  wr_data is valid this cycle.
REQ-007 wr_ready  output  1  controller accepts wr_data this cycle.
REQ-008 start  input  1  one-cycle request to begin scrolling.
REQ-009 clear  input  1  one-cycle request to empty the message and stop.
REQ-010 data  output  4  character to the display loader.
REQ-011 char_position  output  2  target digit, 0..3, for data.
REQ-012 load  output  1  write strobe; the display captures data at char_position when it is high.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, REFRESH and WAIT.
REQ-015 wr_ready SHALL equal (state==IDLE && len<MSG_DEPTH); a write SHALL occur only when wr_valid && wr_ready.
REQ-016 A write SHALL store wr_data at buf[len] and increment len; len SHALL range 0..MSG_DEPTH.
REQ-017 In IDLE, start with len>=1 SHALL set offset=0 and rd_idx=0, and enter REFRESH on the next edge; start with len==0 SHALL be ignored.
REQ-018 In REFRESH, exactly 4 consecutive cycles SHALL follow, k=0..3, each with load=1, char_position=k and data=buf[rd_idx]; rd_idx SHALL advance by one per cycle and wrap to 0 after len-1.
REQ-019 When len<4, characters SHALL repeat modulo len (len=1: all four digits show buf[0]).
REQ-020 After k=3, the FSM SHALL enter WAIT with tick=0.
REQ-021 In WAIT, tick SHALL increment each cycle; at tick==MAX_COUNT-1 the FSM SHALL set offset=(offset+1) mod len, set rd_idx to the new offset, and enter REFRESH.
REQ-022 In IDLE and WAIT, load SHALL be 0, data SHALL be 0 and char_position SHALL be 0.
REQ-023 clear SHALL take priority over every other input in any state: on the next edge state=IDLE, len=0, offset=0, rd_idx=0, tick=0, load=0.
REQ-024 A clear in the same cycle as an accepted write SHALL discard the write.
REQ-025 start while busy SHALL be ignored.
REQ-026 The first load SHALL occur in the cycle after start is sampled; the scroll period SHALL be 4+MAX_COUNT cycles.

Reset
REQ-027 While reset is high: state=IDLE, len=0, offset=0, rd_idx=0, tick=0, and all outputs 0 except wr_ready, which SHALL be 1.
REQ-028 Reset during REFRESH SHALL abort the sequence with no further load pulses after the reset edge.
REQ-029 Buffer contents need not be reset; they SHALL be unobservable while len==0.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE, REFRESH, WAIT) and the MSG_DEPTH default.
REQ-031 The tick counter SHALL be a sub-module scroll_tick (clk, reset, enable, terminal pulse), parameterised by MAX_COUNT.
REQ-032 The message buffer SHALL be an in-module register array; no memory macro SHALL be used.

Verification (MAX_COUNT=4)
REQ-033 Write 1,2,3,4,5, then start: loads (pos,data)=(0,1)(1,2)(2,3)(3,4); 4 cycles later (0,2)(1,3)(2,4)(3,5); next step (0,3)(1,4)(2,5)(3,1).
REQ-034 Write 16 characters: wr_ready=0 after the 16th; a 17th wr_valid is not stored; writes while busy are refused.
REQ-035 Write only 7, then start: every refresh gives data=7 at positions 0..3; the offset stays 0.
REQ-036 Start with len=0: busy stays 0 and no load pulses occur.
REQ-037 Assert clear on the 2nd REFRESH cycle: no load on the following cycle, busy=0, len=0, wr_ready=1.
REQ-038 Assert reset mid-WAIT, release it, rewrite 9, then start: the first load is (0,9) one cycle after start.
